// File: rtl/ball_logic.sv
// Pong ball engine: serve delay, per-frame motion, wall bounces and paddle hit/miss detection.
// Define BALL_SPEEDUP_EN to make each paddle hit add 1 to the step, saturating at 6.
module ball_logic #(
   parameter int SCREEN_W    = 640,
   parameter int SCREEN_H    = 480,
   parameter int BALL_SIZE   = 8,
   parameter int PADDLE_H    = 64,
   parameter int PADDLE_LX   = 16,
   parameter int PADDLE_RX   = 616,
   parameter int STEP        = 2,
   parameter int SERVE_DELAY = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       serve,
   input  logic       game_over,
   input  logic [9:0] paddle_left_y,
   input  logic [9:0] paddle_right_y,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic       hit_left,
   output logic       hit_right,
   output logic       miss_left,
   output logic       miss_right,
   output logic       ball_active
);

   typedef enum logic [1:0] {IDLE, DELAY, PLAY} state_t;

   localparam int CW = $clog2(SERVE_DELAY + 1);

   localparam logic [9:0]  CENTRE_X   = 10'((SCREEN_W - BALL_SIZE) / 2);
   localparam logic [9:0]  CENTRE_Y   = 10'((SCREEN_H - BALL_SIZE) / 2);
   localparam logic [9:0]  Y_MAX      = 10'(SCREEN_H - BALL_SIZE);
   localparam logic [9:0]  LEFT_STOP  = 10'(PADDLE_LX);
   localparam logic [9:0]  RIGHT_STOP = 10'(PADDLE_RX - BALL_SIZE);
   localparam logic [9:0]  STEP_INIT  = 10'(STEP);
   localparam logic [10:0] YMAX_W     = 11'(SCREEN_H - BALL_SIZE);
   localparam logic [10:0] LX_W       = 11'(PADDLE_LX);
   localparam logic [10:0] RX_W       = 11'(PADDLE_RX);
   localparam logic [10:0] BSZ_W      = 11'(BALL_SIZE);
   localparam logic [10:0] PH_W       = 11'(PADDLE_H);

   state_t          state;
   logic            dir_right;
   logic            dir_down;
   logic            tick_d;
   logic [CW-1:0]   delay_cnt;
   logic [9:0]      pl_y;
   logic [9:0]      pr_y;
   logic [9:0]      speed;

`ifdef BALL_SPEEDUP_EN
   localparam logic [9:0] STEP_MAX = 10'd6;
`else
   assign speed = STEP_INIT;
`endif

   logic [10:0] x_w, y_w, s_w, pl_w, pr_w;
   logic [9:0]  nx, ny;
   logic        ndr, ndd, hl, hr, ml, mr, ov_l, ov_r;

   // Next position/direction from the pre-move ball and the paddles latched on the tick.
   always_comb begin
      x_w  = {1'b0, ball_x};
      y_w  = {1'b0, ball_y};
      s_w  = {1'b0, speed};
      pl_w = {1'b0, pl_y};
      pr_w = {1'b0, pr_y};
      nx   = ball_x;
      ny   = ball_y;
      ndr  = dir_right;
      ndd  = dir_down;
      hl   = 1'b0;
      hr   = 1'b0;
      ml   = 1'b0;
      mr   = 1'b0;
      ov_l = (y_w + BSZ_W > pl_w) && (y_w < pl_w + PH_W);
      ov_r = (y_w + BSZ_W > pr_w) && (y_w < pr_w + PH_W);

      if (dir_down) begin
         if (y_w + s_w >= YMAX_W) begin
            ny  = Y_MAX;
            ndd = 1'b0;
         end else begin
            ny = ball_y + speed;
         end
      end else if (ball_y <= speed) begin
         ny  = '0;
         ndd = 1'b1;
      end else begin
         ny = ball_y - speed;
      end

      if (!dir_right) begin
         if (x_w <= LX_W + s_w) begin
            if (ov_l) begin
               hl  = 1'b1;
               nx  = LEFT_STOP;
               ndr = 1'b1;
            end else begin
               ml = 1'b1;
            end
         end else begin
            nx = ball_x - speed;
         end
      end else begin
         if (x_w + BSZ_W + s_w >= RX_W) begin
            if (ov_r) begin
               hr  = 1'b1;
               nx  = RIGHT_STOP;
               ndr = 1'b0;
            end else begin
               mr = 1'b1;
            end
         end else begin
            nx = ball_x + speed;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         ball_x      <= CENTRE_X;
         ball_y      <= CENTRE_Y;
         dir_right   <= 1'b1;
         dir_down    <= 1'b1;
         delay_cnt   <= '0;
         tick_d      <= 1'b0;
         pl_y        <= '0;
         pr_y        <= '0;
         hit_left    <= 1'b0;
         hit_right   <= 1'b0;
         miss_left   <= 1'b0;
         miss_right  <= 1'b0;
         ball_active <= 1'b0;
`ifdef BALL_SPEEDUP_EN
         speed       <= STEP_INIT;
`endif
      end else begin
         hit_left   <= 1'b0;
         hit_right  <= 1'b0;
         miss_left  <= 1'b0;
         miss_right <= 1'b0;
         tick_d     <= 1'b0;
         if (game_over) begin
            state       <= IDLE;
            ball_x      <= CENTRE_X;
            ball_y      <= CENTRE_Y;
            ball_active <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (serve) begin
                     state     <= DELAY;
                     delay_cnt <= '0;
`ifdef BALL_SPEEDUP_EN
                     speed     <= STEP_INIT;
`endif
                  end
               end
               DELAY: begin
                  if (frame_tick) begin
                     delay_cnt <= delay_cnt + 1'b1;
                     if (delay_cnt == CW'(SERVE_DELAY - 1)) begin
                        state       <= PLAY;
                        ball_active <= 1'b1;
                     end
                  end
               end
               PLAY: begin
                  if (frame_tick) begin
                     tick_d <= 1'b1;
                     pl_y   <= paddle_left_y;
                     pr_y   <= paddle_right_y;
                  end
                  if (tick_d) begin
                     hit_left   <= hl;
                     hit_right  <= hr;
                     miss_left  <= ml;
                     miss_right <= mr;
                     if (ml || mr) begin
                        state       <= IDLE;
                        ball_active <= 1'b0;
                        ball_x      <= CENTRE_X;
                        ball_y      <= CENTRE_Y;
                        dir_right   <= mr;
                        dir_down    <= 1'b1;
                     end else begin
                        ball_x    <= nx;
                        ball_y    <= ny;
                        dir_right <= ndr;
                        dir_down  <= ndd;
`ifdef BALL_SPEEDUP_EN
                        if ((hl || hr) && speed < STEP_MAX)
                           speed <= speed + 1'b1;
`endif
                     end
                  end
               end
               default: begin
                  state       <= IDLE;
                  ball_active <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ball_logic.sv
// Directed bench for ball_logic: velocity-based reference model checked every cycle,
// plus hand-computed trajectory checkpoints (ticks counted from the first PLAY tick).
module tb_ball_logic;

   localparam int W = 640, H = 480, B = 8, PH = 64, LX = 16, RX = 616;
   localparam int STEP = 2, SERVE_DELAY = 60;
   localparam int CX = (W - B) / 2, CY = (H - B) / 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       frame_tick = 1'b0;
   logic       serve = 1'b0;
   logic       game_over = 1'b0;
   logic [9:0] paddle_left_y = '0;
   logic [9:0] paddle_right_y = '0;
   logic [9:0] ball_x, ball_y;
   logic       hit_left, hit_right, miss_left, miss_right, ball_active;

   ball_logic #(
      .SCREEN_W(W), .SCREEN_H(H), .BALL_SIZE(B), .PADDLE_H(PH),
      .PADDLE_LX(LX), .PADDLE_RX(RX), .STEP(STEP), .SERVE_DELAY(SERVE_DELAY)
   ) dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .serve(serve),
      .game_over(game_over), .paddle_left_y(paddle_left_y),
      .paddle_right_y(paddle_right_y), .ball_x(ball_x), .ball_y(ball_y),
      .hit_left(hit_left), .hit_right(hit_right), .miss_left(miss_left),
      .miss_right(miss_right), .ball_active(ball_active)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Reference model: position plus signed unit direction, speed, serve countdown.
   int       m_x, m_y, m_sx, m_sy, m_step, m_wait, m_cl, m_cr;
   bit       m_play, m_serving, m_pending, started = 1'b0;
   bit [3:0] m_ev;   // {hit_left, hit_right, miss_left, miss_right}

   task automatic model_move(input int pl, input int pr);
      int nx, ny, nsx, nsy;
      bit miss_l, miss_r;
      nx = m_x; ny = m_y; nsx = m_sx; nsy = m_sy; miss_l = 0; miss_r = 0;
      if (m_sy > 0) begin
         if (m_y + m_step >= H - B) begin ny = H - B; nsy = -1; end
         else ny = m_y + m_step;
      end else begin
         if (m_y <= m_step) begin ny = 0; nsy = 1; end
         else ny = m_y - m_step;
      end
      if (m_sx < 0 && m_x <= LX + m_step) begin
         if (m_y + B > pl && m_y < pl + PH) begin m_ev[3] = 1; nx = LX; nsx = 1; end
         else begin m_ev[1] = 1; miss_l = 1; end
      end else if (m_sx > 0 && m_x + B + m_step >= RX) begin
         if (m_y + B > pr && m_y < pr + PH) begin m_ev[2] = 1; nx = RX - B; nsx = -1; end
         else begin m_ev[0] = 1; miss_r = 1; end
      end else begin
         nx = m_x + m_sx * m_step;
      end
      if (miss_l || miss_r) begin
         m_x = CX; m_y = CY; m_sx = miss_l ? -1 : 1; m_sy = 1; m_play = 0;
      end else begin
         m_x = nx; m_y = ny; m_sx = nsx; m_sy = nsy;
`ifdef BALL_SPEEDUP_EN
         if ((m_ev[3] || m_ev[2]) && m_step < 6) m_step++;
`endif
      end
   endtask

   always @(posedge clk) begin : model
      bit do_move;
      int lat_l, lat_r;
      m_ev = '0;
      if (reset) begin
         m_x = CX; m_y = CY; m_sx = 1; m_sy = 1; m_step = STEP; m_wait = 0;
         m_cl = 0; m_cr = 0; m_play = 0; m_serving = 0; m_pending = 0; started = 1;
      end else if (game_over) begin
         m_play = 0; m_serving = 0; m_pending = 0; m_x = CX; m_y = CY;
      end else if (m_serving) begin
         if (frame_tick) begin
            m_wait--;
            if (m_wait == 0) begin m_serving = 0; m_play = 1; end
         end
      end else if (!m_play) begin
         if (serve) begin m_serving = 1; m_wait = SERVE_DELAY; m_step = STEP; end
      end else begin
         do_move = m_pending; lat_l = m_cl; lat_r = m_cr;
         m_pending = frame_tick;
         if (frame_tick) begin m_cl = int'(paddle_left_y); m_cr = int'(paddle_right_y); end
         if (do_move) model_move(lat_l, lat_r);
      end
   end

   always @(negedge clk) begin
      if (started) begin
         check("outputs", {ball_x, ball_y, ball_active, hit_left, hit_right, miss_left, miss_right},
               {10'(m_x), 10'(m_y), m_play, m_ev});
         check("one_event", 64'($countones({hit_left, hit_right, miss_left, miss_right}) <= 1), 64'd1);
      end
   end

   // Literal checkpoint against both the DUT and the model.
   task automatic check_pos(input string name, input int x, input int y, input bit act);
      check({name, "_dut"}, {ball_x, ball_y, ball_active}, {10'(x), 10'(y), act});
      check({name, "_model"}, {10'(m_x), 10'(m_y), m_play}, {10'(x), 10'(y), act});
   endtask

   int track = 0;   // 0 fixed paddles, 1 follow the ball, 2 avoid the ball

   task automatic do_tick(output logic [3:0] ev);
      @(posedge clk); #1;
      if (track == 1) begin
         paddle_left_y  = 10'((m_y >= 20) ? m_y - 20 : 0);
         paddle_right_y = paddle_left_y;
      end else if (track == 2) begin
         paddle_left_y  = (m_y < 240) ? 10'd400 : 10'd0;
         paddle_right_y = paddle_left_y;
      end
      frame_tick = 1'b1;
      @(posedge clk); #1 frame_tick = 1'b0;
      @(posedge clk); #1 ev = {hit_left, hit_right, miss_left, miss_right};
      @(posedge clk); #1;
   endtask

   task automatic ticks(input int n, output logic [3:0] ev_or);
      logic [3:0] ev;
      ev_or = '0;
      for (int i = 0; i < n; i++) begin do_tick(ev); ev_or |= ev; end
   endtask

   task automatic run_until_event(input int max, output int n, output logic [3:0] ev);
      n = 0; ev = '0;
      while (ev == 4'b0 && n < max) begin do_tick(ev); n++; end
   endtask

   task automatic serve_pulse();
      @(posedge clk); #1 serve = 1'b1;
      @(posedge clk); #1 serve = 1'b0;
   endtask

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [3:0] ev;
      int n, x0, y0, hits;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      check_pos("reset", CX, CY, 0);
      check("reset_events", {hit_left, hit_right, miss_left, miss_right}, 4'b0);
      check("model_centre", 64'(m_x * 1000 + m_y), 64'(316 * 1000 + 236));

      // Rally 1: right paddle parked where the ball arrives, left paddle away.
      paddle_right_y = 10'd400;
      paddle_left_y  = 10'd0;
      serve_pulse();
      ticks(59, ev);
      check_pos("delay_59", CX, CY, 0);
      ticks(1, ev);
      check_pos("delay_60", CX, CY, 1);
      ticks(1, ev);
      check_pos("first_move", 318, 238, 1);

`ifndef BALL_SPEEDUP_EN
      ticks(116, ev);
      check_pos("before_floor", 550, 470, 1);
      check("no_event_rally1", ev, 4'b0);
      ticks(1, ev);
      check_pos("floor_clamp", 552, 472, 1);
      ticks(1, ev);
      check_pos("after_floor", 554, 470, 1);
      run_until_event(100, n, ev);
      check("hit_right_tick", n, 27);
      check("hit_right_event", ev, 4'b0100);
      check_pos("hit_right_pos", 608, 416, 1);
      run_until_event(400, n, ev);
      check("miss_left_tick", n, 296);
      check("miss_left_event", ev, 4'b0010);
      check_pos("miss_left_pos", CX, CY, 0);

      // Rally 2: served leftwards toward the player who missed.
      paddle_left_y = 10'd380;
      serve_pulse();
      ticks(30, ev);
      serve_pulse();
      ticks(29, ev);
      check_pos("delay2_59", CX, CY, 0);
      ticks(1, ev);
      check_pos("delay2_60", CX, CY, 1);
      run_until_event(200, n, ev);
      check("hit_left_tick", n, 150);
      check("hit_left_event", ev, 4'b1000);
      check_pos("hit_left_pos", 16, 408, 1);
      ticks(1, ev);
      check_pos("after_hit_left", 18, 406, 1);
`else
      // Speedup: three paddle returns lift the step from 2 to 5; a new serve restores 2.
      track = 1;
      hits = 0; n = 0;
      while (hits < 3 && n < 3000) begin
         do_tick(ev);
         n++;
         if (ev[3] || ev[2]) hits++;
      end
      check("three_hits", hits, 3);
      x0 = int'(ball_x);
      ticks(1, ev);
      check("step_after_3_hits", (int'(ball_x) > x0) ? int'(ball_x) - x0 : x0 - int'(ball_x), 5);
      track = 2;
      run_until_event(3000, n, ev);
      check("speedup_miss", 64'(ev[1] | ev[0]), 64'd1);
      track = 0;
      serve_pulse();
      ticks(SERVE_DELAY, ev);
      x0 = int'(ball_x); y0 = int'(ball_y);
      ticks(1, ev);
      check("step_restored_x", (int'(ball_x) > x0) ? int'(ball_x) - x0 : x0 - int'(ball_x), 2);
      check("step_restored_y", (int'(ball_y) > y0) ? int'(ball_y) - y0 : y0 - int'(ball_y), 2);
`endif

      // game_over freezes play and blocks serve.
      @(posedge clk); #1 game_over = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_pos("game_over", CX, CY, 0);
      serve_pulse();
      ticks(SERVE_DELAY + 2, ev);
      check_pos("game_over_serve", CX, CY, 0);
      check("game_over_events", ev, 4'b0);
      game_over = 1'b0;

      // Reset landing on a pending motion step.
      serve_pulse();
      ticks(SERVE_DELAY + 3, ev);
      check("replay_active", ball_active, 1'b1);
      @(posedge clk); #1 frame_tick = 1'b1;
      @(posedge clk); #1 frame_tick = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      check("reset_mid_events", {hit_left, hit_right, miss_left, miss_right}, 4'b0);
      @(posedge clk); #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_pos("reset_mid_play", CX, CY, 0);
      check("reset_mid_events2", {hit_left, hit_right, miss_left, miss_right}, 4'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
